// File: rtl/pc_gen.sv
// Fetch-side program-counter generator with execute-stage redirects.
// Optional direct-mapped branch target buffer enabled by defining BTB_EN.
module pc_gen #(
    parameter int unsigned        XLEN      = 32,
    parameter logic [XLEN-1:0]    RESET_PC  = '0,
    parameter int unsigned        BTB_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_op,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_c,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] npc,
    output logic [31:0]     redirect_cnt
);

    localparam logic [1:0] OpPcImm  = 2'b01;
    localparam logic [1:0] OpRd1Imm = 2'b10;

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] npc_int;
    logic            accept;

    // Redirects are only honoured before halt.
    assign accept = redirect_valid && (state_q != StHalt);

    always_comb begin
        target = redirect_pc + XLEN'(4);
        case (redirect_op)
            OpPcImm:  target = redirect_pc + imm;
            OpRd1Imm: target = alu_c & ~XLEN'(1);
            default:  target = redirect_pc + XLEN'(4);
        endcase
    end

`ifdef BTB_EN
    localparam int unsigned IdxW = $clog2(BTB_DEPTH);
    localparam int unsigned TagW = XLEN - IdxW - 2;

    logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;
    logic [TagW-1:0]      btb_tag_q    [BTB_DEPTH];
    logic [TagW-1:0]      btb_tag_d    [BTB_DEPTH];
    logic [XLEN-1:0]      btb_target_q [BTB_DEPTH];
    logic [XLEN-1:0]      btb_target_d [BTB_DEPTH];
    logic [IdxW-1:0]      rd_idx, wr_idx;
    logic [TagW-1:0]      rd_tag, wr_tag;
    logic                 hit;

    assign rd_idx = pc_q[IdxW+1:2];
    assign rd_tag = pc_q[XLEN-1:IdxW+2];
    assign wr_idx = redirect_pc[IdxW+1:2];
    assign wr_tag = redirect_pc[XLEN-1:IdxW+2];
    assign hit    = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);

    always_comb begin
        npc_int = hit ? btb_target_q[rd_idx] : pc_q + XLEN'(4);
    end

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (accept) begin
            if (redirect_op == OpPcImm || redirect_op == OpRd1Imm) begin
                btb_valid_d[wr_idx]  = 1'b1;
                btb_tag_d[wr_idx]    = wr_tag;
                btb_target_d[wr_idx] = target;
            end else if (btb_tag_q[wr_idx] == wr_tag) begin
                // Sequential redirect: drop a stale prediction for this exact PC only.
                btb_valid_d[wr_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_q <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        btb_tag_q    <= btb_tag_d;
        btb_target_q <= btb_target_d;
    end
`else
    always_comb begin
        npc_int = pc_q + XLEN'(4);
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = halt_req ? StHalt : StRun;
            StHalt:  state_d = StHalt;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (accept) begin
            pc_d = target;
        end else if (state_q == StRun && !stall) begin
            pc_d = npc_int;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Output logic
    always_comb begin
        pc_valid = (state_q == StRun);
    end

    assign pc           = pc_q;
    assign npc          = npc_int;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; BTB checks active when BTB_EN is defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_op = 2'b00;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] alu_c = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] npc;
    logic [31:0] redirect_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen #(
        .XLEN      (32),
        .RESET_PC  (32'h8000_0000),
        .BTB_DEPTH (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_op    (redirect_op),
        .redirect_pc    (redirect_pc),
        .imm            (imm),
        .alu_c          (alu_c),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .npc            (npc),
        .redirect_cnt   (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic redir(input logic [1:0] op, input logic [31:0] rpc, input logic [31:0] im);
        redirect_valid = 1'b1;
        redirect_op    = op;
        redirect_pc    = rpc;
        imm            = im;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Reset and boot
        #12;
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_valid", {31'd0, pc_valid}, 32'd0);
        check("rst_npc", npc, 32'h8000_0004);
        check("rst_cnt", redirect_cnt, 32'd0);
        rst_n = 1'b1;
        tick();
        check("boot_pc", pc, 32'h8000_0000);
        check("run_valid", {31'd0, pc_valid}, 32'd1);
        tick();
        check("step1", pc, 32'h8000_0004);
        tick();
        check("step2", pc, 32'h8000_0008);

        // Stall holds, redirect beats stall
        stall = 1'b1;
        tick();
        tick();
        tick();
        check("stall_hold", pc, 32'h8000_0008);
        redir(2'b01, 32'h0000_0100, 32'hFFFF_FFF0);
        check("stall_redir_pc", pc, 32'h0000_00F0);
        check("cnt1", redirect_cnt, 32'd1);
        check("npc_f0", npc, 32'h0000_00F4);
        stall = 1'b0;
        tick();
        check("after_redir_step", pc, 32'h0000_00F4);

        // JALR alignment, wrap, op 2'b11
        alu_c = 32'h0000_2003;
        redir(2'b10, 32'h0000_00C4, 32'h0);
        check("jalr_align", pc, 32'h0000_2002);
        redir(2'b00, 32'hFFFF_FFFC, 32'h0);
        check("pc4_wrap", pc, 32'h0000_0000);
        redir(2'b11, 32'h0000_0050, 32'h1234);
        check("op11_pc4", pc, 32'h0000_0054);
        check("cnt4", redirect_cnt, 32'd4);

        // BTB train / hit / invalidate / alias
        redir(2'b01, 32'h0000_0020, 32'h0000_0060);
        check("train_pc", pc, 32'h0000_0080);
        redir(2'b01, 32'h0000_0010, 32'h0000_0010);
        check("visit20_pc", pc, 32'h0000_0020);
`ifdef BTB_EN
        check("btb_hit_npc", npc, 32'h0000_0080);
        tick();
        check("btb_hit_follow", pc, 32'h0000_0080);
`else
        check("nobtb_npc", npc, 32'h0000_0024);
        tick();
        check("nobtb_follow", pc, 32'h0000_0024);
`endif
        redir(2'b00, 32'h0000_0020, 32'h0);
        check("inval_pc", pc, 32'h0000_0024);
        redir(2'b01, 32'h0000_0010, 32'h0000_0010);
        check("revisit20_npc", npc, 32'h0000_0024);
        redir(2'b01, 32'h0000_0020, 32'h0000_0060);
        redir(2'b00, 32'h0000_0040, 32'h0);
        check("alias_redir_pc", pc, 32'h0000_0044);
        redir(2'b01, 32'h0000_0010, 32'h0000_0030);
        check("alias_miss_npc", npc, 32'h0000_0044);
        redir(2'b01, 32'h0000_0010, 32'h0000_0010);
`ifdef BTB_EN
        check("alias_kept_npc", npc, 32'h0000_0080);
`else
        check("alias_kept_npc", npc, 32'h0000_0024);
`endif
        check("cnt12", redirect_cnt, 32'd12);

        // Halt together with redirect
        halt_req = 1'b1;
        redir(2'b01, 32'h0000_0100, 32'h0000_0300);
        halt_req = 1'b0;
        check("halt_pc", pc, 32'h0000_0400);
        check("halt_valid", {31'd0, pc_valid}, 32'd0);
        check("halt_cnt", redirect_cnt, 32'd13);
        stall = 1'b1;
        redir(2'b01, 32'h0000_0200, 32'h0000_0010);
        stall = 1'b0;
        tick();
        redir(2'b00, 32'h0000_0300, 32'h0);
        check("halt_hold_pc", pc, 32'h0000_0400);
        check("halt_hold_cnt", redirect_cnt, 32'd13);
        check("halt_hold_valid", {31'd0, pc_valid}, 32'd0);

        // Asynchronous reset out of halt
        rst_n = 1'b0;
        #2;
        check("rst2_pc", pc, 32'h8000_0000);
        check("rst2_cnt", redirect_cnt, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst2_run", {31'd0, pc_valid}, 32'd1);

        // Counter saturation via backdoor preload
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        redir(2'b00, 32'h0000_0100, 32'h0);
        check("sat_reach", redirect_cnt, 32'hFFFF_FFFF);
        redir(2'b00, 32'h0000_0200, 32'h0);
        check("sat_hold", redirect_cnt, 32'hFFFF_FFFF);
        check("sat_pc", pc, 32'h0000_0204);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-side program-counter generator and successor to the combinational next-PC selector. Holds the architectural PC in a register and advances it every non-stalled cycle. Accepts redirects from execute using the same three-way target selection (pc+4, pc+imm, rd1+imm with bit 0 cleared). Optionally predicts taken control flow with a small direct-mapped branch target buffer. Sits between the execute stage's redirect logic and instruction fetch.

## Interface
Parameters:
- XLEN, 32, PC/data width; legal ≥ 8.
- RESET_PC, 0, PC value loaded by reset.
- BTB_DEPTH, 8, BTB entries; power of two, ≥ 2; ignored without BTB_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  fetch cannot accept a new PC this cycle.
- halt_req  in  1  request to stop fetch until reset.
- redirect_valid  in  1  execute-stage redirect this cycle.
- redirect_op  in  2  target select: 2'b00 PC_4, 2'b01 PC_IMM, 2'b10 RD1_IMM, 2'b11 treated as PC_4.
- redirect_pc  in  XLEN  PC of the redirecting instruction.
- imm  in  XLEN  immediate for PC_IMM.
- alu_c  in  XLEN  rd1+imm result for RD1_IMM.
- pc  out  XLEN  current fetch PC.
- pc_valid  out  1  pc is a real fetch request.
- npc  out  XLEN  predicted next PC (pc+4, or BTB target on hit).
- redirect_cnt  out  32  count of accepted redirects, saturating.

## Operation
- Target: PC_4 → redirect_pc+4; PC_IMM → redirect_pc+imm; RD1_IMM → {alu_c[XLEN-1:1],1'b0}; 2'b11 → redirect_pc+4. All sums are modulo 2^XLEN; carry is dropped.
- FSM states:
  - BOOT: entered on reset. pc_valid=0.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, pc frozen.
- FSM transitions:
  - BOOT → RUN after exactly one clock.
  - RUN → HALT when halt_req=1.
  - HALT is left only by reset.
- PC update priority in BOOT/RUN:
  1. redirect_valid → pc ← target.
  2. Else RUN and !stall → pc ← npc.
  3. Else hold.
- In BOOT, pc holds RESET_PC unless redirect_valid.
- Halt with redirect: if halt_req and redirect_valid are both 1 in RUN, the redirect target loads, then HALT is entered.
- In HALT: redirect_valid and stall are ignored. redirect_cnt does not count.
- redirect_cnt increments once per accepted redirect (BOOT or RUN) and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - pc=RESET_PC, pc_valid=0, npc=RESET_PC+4, redirect_cnt=0.
  - All BTB valid bits=0; state BOOT.
- Reset assertion is asynchronous and aborts any state, including HALT.
- npc is combinational from pc and BTB contents; zero-cycle lookup.
- Redirect latency: target appears on pc one cycle after redirect_valid is sampled.
- A stall has no effect in the cycle where redirect_valid=1.
- The BTB is written at the edge that samples the redirect. A lookup in that same cycle sees the pre-write contents.

## Configuration
- BTB_EN defined:
  - BTB of BTB_DEPTH entries. Each entry holds {valid, tag=pc[XLEN-1:log2(BTB_DEPTH)+2], target}.
  - Index = pc[log2(BTB_DEPTH)+1:2].
  - Lookup hit (valid and tag match on current pc) → npc=target; miss → npc=pc+4.
  - Redirect with op PC_IMM or RD1_IMM writes the entry for redirect_pc with the computed target (valid=1).
  - Redirect with op PC_4 or 2'b11 clears that entry's valid bit, only if the tag matches.
- BTB_EN undefined: no table; npc=pc+4 always. Redirect behaviour and redirect_cnt are unchanged.

## Test plan
- Reset/boot: release rst_n with RESET_PC=32'h8000_0000 → pc=32'h8000_0000 and pc_valid=0 for 1 cycle; then pc steps to 8000_0004, 8000_0008 with pc_valid=1.
- Stall vs redirect: stall=1 for 3 cycles → pc holds. Then stall=1, redirect_valid=1, op=PC_IMM, redirect_pc=32'h100, imm=32'hFFFF_FFF0 → pc=32'h0F0 next cycle; redirect_cnt=1.
- JALR alignment: op=RD1_IMM, alu_c=32'h0000_2003 → pc=32'h0000_2002. Wrap: op=PC_4, redirect_pc=32'hFFFF_FFFC → pc=0.
- Halt: halt_req and redirect (PC_IMM to 32'h400) in the same cycle → pc=32'h400, pc_valid=0. Further redirects and stalls leave pc and redirect_cnt unchanged until rst_n is pulsed.
- BTB_EN, BTB_DEPTH=8:
  - Redirect PC_IMM at redirect_pc=32'h20 to 32'h80.
  - Later, when pc=32'h20, npc=32'h80 and pc advances to 32'h80.
  - Redirect PC_4 at 32'h20 → entry invalidated; the next visit to 32'h20 gives npc=32'h24.
  - An alias at 32'h40 (same index, different tag) misses and does not invalidate.
- Counter saturation: force redirect_cnt near max via 2^32 redirects or a bench backdoor → count holds at 32'hFFFF_FFFF.
